data_sync_ctrl: RTL

Destination-domain receiver for a multi-bit bus crossing from another clock domain, qualified by a single-bit enable. Only the enable passes through a parametrised N-stage flop synchronizer. The bus is not synchronized bit-wise; it is captured as a whole only when a synchronized enable event is detected, which relies on the source holding the bus stable. The block adds level or toggle enable encoding, a valid/ready hold with overrun detection, and a transfer counter. It is used for config and data buses entering the CLK domain.

---
 rtl/data_sync_ctrl_if.sv | 26 ++
 rtl/data_sync_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/data_sync_ctrl_if.sv
// Bus/handshake bundle for data_sync_ctrl: the source-side bus and enable,
// consumer handshake, and the captured-data outputs.
interface data_sync_ctrl_if #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] UNSYNC_BUS;
    logic                 BUS_EN;
    logic                 DST_READY;
    logic                 CLR_ERR;
    logic [BUS_WIDTH-1:0] SYNC_BUS;
    logic                 ENABLE_PULSE;
    logic                 VALID;
    logic                 OVERRUN;
    logic [CNT_WIDTH-1:0] XFER_CNT;

    modport master (
        output UNSYNC_BUS, BUS_EN, DST_READY, CLR_ERR,
        input  SYNC_BUS, ENABLE_PULSE, VALID, OVERRUN, XFER_CNT
    );

    modport slave (
        input  UNSYNC_BUS, BUS_EN, DST_READY, CLR_ERR,
        output SYNC_BUS, ENABLE_PULSE, VALID, OVERRUN, XFER_CNT
    );
endinterface

// File: rtl/data_sync_ctrl.sv
// CLK-domain receiver for a bus qualified by an enable from another domain:
// only the enable is synchronized; the bus is captured whole on an enable event.
module data_sync_ctrl #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int EN_MODE    = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    data_sync_ctrl_if.slave  bus_if
);

    generate
        if (NUM_STAGES < 2 || NUM_STAGES > 5) begin : g_bad_stages
            $error("data_sync_ctrl: NUM_STAGES must be in 2..5");
        end
    endgenerate

    logic [NUM_STAGES-1:0] sync_r;
    logic                  p_r;
    logic [BUS_WIDTH-1:0]  sync_bus_r;
    logic                  pulse_r;
    logic                  valid_r;
    logic                  ovr_r;
    logic [CNT_WIDTH-1:0]  cnt_r;

    logic                  ev_s;
    logic                  valid_nxt_s;
    logic                  ovr_nxt_s;

    // Enable synchronizer chain plus edge-history flop; no logic between stages.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_r <= {NUM_STAGES{1'b0}};
            p_r    <= 1'b0;
        end else begin
            sync_r <= {sync_r[NUM_STAGES-2:0], bus_if.BUS_EN};
            p_r    <= sync_r[NUM_STAGES-1];
        end
    end

    // Event detection: rising edge in level mode, any edge in toggle mode.
    always_comb begin
        ev_s = 1'b0;
        if (EN_MODE != 0) begin
            ev_s = sync_r[NUM_STAGES-1] ^ p_r;
        end else begin
            ev_s = sync_r[NUM_STAGES-1] & ~p_r;
        end
    end

    // Valid/overrun next state; a capture concurrent with consume is not an overrun.
    always_comb begin
        valid_nxt_s = valid_r;
        ovr_nxt_s   = ovr_r;
        if (bus_if.CLR_ERR) begin
            ovr_nxt_s = 1'b0;
        end else begin
            ovr_nxt_s = ovr_r;
        end
        if (ev_s) begin
            valid_nxt_s = 1'b1;
            if (valid_r && !bus_if.DST_READY) begin
                ovr_nxt_s = 1'b1;
            end else begin
                ovr_nxt_s = ovr_nxt_s;
            end
        end else if (valid_r && bus_if.DST_READY) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // Registered capture, strobe, handshake state and transfer counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_bus_r <= {BUS_WIDTH{1'b0}};
            pulse_r    <= 1'b0;
            valid_r    <= 1'b0;
            ovr_r      <= 1'b0;
            cnt_r      <= {CNT_WIDTH{1'b0}};
        end else begin
            pulse_r <= ev_s;
            valid_r <= valid_nxt_s;
            ovr_r   <= ovr_nxt_s;
            if (ev_s) begin
                sync_bus_r <= bus_if.UNSYNC_BUS;
                cnt_r      <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                sync_bus_r <= sync_bus_r;
                cnt_r      <= cnt_r;
            end
        end
    end

    assign bus_if.SYNC_BUS     = sync_bus_r;
    assign bus_if.ENABLE_PULSE = pulse_r;
    assign bus_if.VALID        = valid_r;
    assign bus_if.OVERRUN      = ovr_r;
    assign bus_if.XFER_CNT     = cnt_r;

endmodule
